dn_receiver: RTL and testbench

Download-stream receiver inside `pcw_core` that accepts the boot loader's byte stream and commits each byte to system memory. Input is `dn_go`/`dn_wr`/`dn_addr`/`dn_data` plus `execute_enable`/`execute_addr`. Bytes are buffered in a small FIFO and written through a req/ack port to the SDRAM arbiter. The CPU is held until every queued byte is committed; the block then issues a one-cycle start pulse with the execution address.

---
 rtl/dn_receiver.sv | 177 +++++++++++++++++
 tb/tb_dn_receiver.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dn_receiver.sv
// rtl/dn_receiver.sv - download-stream receiver: captures loader bytes, queues them, commits them to memory, then releases the CPU
module dn_receiver #(
   parameter int                FIFO_DEPTH = 4,
   parameter int                MEM_AW     = 22,
   parameter logic [MEM_AW-1:0] BASE_ADDR  = '0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              dn_go,
   input  logic              dn_wr,
   input  logic [15:0]       dn_addr,
   input  logic [7:0]        dn_data,
   input  logic              execute_enable,
   input  logic [15:0]       execute_addr,
   output logic              dn_wait,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_dout,
   input  logic              mem_ack,
   output logic              cpu_hold,
   output logic              cpu_start,
   output logic [15:0]       start_addr,
   output logic [16:0]       byte_count,
   output logic [7:0]        checksum,
   output logic              overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_START
   } state_t;

   state_t           state;
   logic             pending;
   logic             dn_wr_q;
   logic [15:0]      fifo_addr [FIFO_DEPTH];
   logic [7:0]       fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;

   logic capture_en;
   logic wr_edge;
   logic fifo_empty;
   logic fifo_full;
   logic bypass;
   logic push;
   logic pop;
   logic drop;
   logic acked;
   logic busy;

   function automatic logic [MEM_AW-1:0] to_mem(input logic [15:0] a);
      return MEM_AW'(a) + BASE_ADDR;
   endfunction

   // The request register is a slot of its own, so one byte can be in
   // flight while FIFO_DEPTH more wait behind it.
   always_comb begin
      capture_en = (state == S_LOAD) || (state == S_DRAIN);
      wr_edge    = dn_wr && !dn_wr_q && dn_go && capture_en;
      fifo_empty = (fifo_count == '0);
      fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
      pop        = !mem_req && !fifo_empty;
      bypass     = !mem_req && fifo_empty && wr_edge;
      push       = wr_edge && !bypass && !fifo_full;
      drop       = wr_edge && !bypass && fifo_full;
      acked      = mem_req && mem_ack;
      busy       = mem_req || !fifo_empty || wr_edge;
      dn_wait    = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_addr[wr_ptr] <= dn_addr;
         fifo_data[wr_ptr] <= dn_data;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dn_wr_q    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_dout   <= '0;
      end else begin
         dn_wr_q <= dn_wr;
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (acked) begin
            mem_req <= 1'b0;
         end else if (pop) begin
            mem_req  <= 1'b1;
            mem_addr <= to_mem(fifo_addr[rd_ptr]);
            mem_dout <= fifo_data[rd_ptr];
         end else if (bypass) begin
            mem_req  <= 1'b1;
            mem_addr <= to_mem(dn_addr);
            mem_dout <= dn_data;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= S_IDLE;
         pending    <= 1'b0;
         cpu_hold   <= 1'b1;
         cpu_start  <= 1'b0;
         start_addr <= '0;
         byte_count <= '0;
         checksum   <= '0;
         overflow   <= 1'b0;
      end else begin
         cpu_start <= 1'b0;
         if (acked) begin
            byte_count <= byte_count + 17'd1;
            checksum   <= checksum + mem_dout;
         end
         if (drop)
            overflow <= 1'b1;
         if (execute_enable && capture_en) begin
            start_addr <= execute_addr;
            pending    <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (dn_go) begin
                  state      <= S_LOAD;
                  cpu_hold   <= 1'b1;
                  pending    <= 1'b0;
                  byte_count <= '0;
                  checksum   <= '0;
                  overflow   <= 1'b0;
               end
            end
            S_LOAD: begin
               if (!dn_go || pending)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               // A byte captured this very cycle still counts as work to drain.
               if (!busy) begin
                  if (pending) begin
                     state     <= S_START;
                     cpu_start <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else if (!dn_go) begin
                     state <= S_IDLE;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dn_receiver.sv
// tb/tb_dn_receiver.sv - directed bench for dn_receiver with an ordered-write scoreboard model
module tb_dn_receiver;

   localparam int AW = 22;

   logic          clk_sys;
   logic          reset;
   logic          dn_go;
   logic          dn_wr;
   logic [15:0]   dn_addr;
   logic [7:0]    dn_data;
   logic          execute_enable;
   logic [15:0]   execute_addr;
   logic          mem_ack;
   logic          dn_wait,    b_dn_wait;
   logic          mem_req,    b_mem_req;
   logic [AW-1:0] mem_addr,   b_mem_addr;
   logic [7:0]    mem_dout,   b_mem_dout;
   logic          cpu_hold,   b_cpu_hold;
   logic          cpu_start,  b_cpu_start;
   logic [15:0]   start_addr, b_start_addr;
   logic [16:0]   byte_count, b_byte_count;
   logic [7:0]    checksum,   b_checksum;
   logic          overflow,   b_overflow;

   dn_receiver #(.FIFO_DEPTH(4), .MEM_AW(AW), .BASE_ADDR(22'h000000)) dut (
      .clk_sys(clk_sys), .reset(reset), .dn_go(dn_go), .dn_wr(dn_wr),
      .dn_addr(dn_addr), .dn_data(dn_data), .execute_enable(execute_enable),
      .execute_addr(execute_addr), .dn_wait(dn_wait), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_ack(mem_ack),
      .cpu_hold(cpu_hold), .cpu_start(cpu_start), .start_addr(start_addr),
      .byte_count(byte_count), .checksum(checksum), .overflow(overflow)
   );

   dn_receiver #(.FIFO_DEPTH(4), .MEM_AW(AW), .BASE_ADDR(22'h3FFFF0)) u_base (
      .clk_sys(clk_sys), .reset(reset), .dn_go(dn_go), .dn_wr(dn_wr),
      .dn_addr(dn_addr), .dn_data(dn_data), .execute_enable(execute_enable),
      .execute_addr(execute_addr), .dn_wait(b_dn_wait), .mem_req(b_mem_req),
      .mem_addr(b_mem_addr), .mem_dout(b_mem_dout), .mem_ack(mem_ack),
      .cpu_hold(b_cpu_hold), .cpu_start(b_cpu_start), .start_addr(b_start_addr),
      .byte_count(b_byte_count), .checksum(b_checksum), .overflow(b_overflow)
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t  exp_q[$];
   int   m_count;
   logic [7:0] m_sum;
   logic m_ovf;
   int   tests, fails, cyc;
   bit   chk_en;
   int   ack_lat, req_age;
   bit   ack_block, force_ack;
   int   acks_seen, starts, ack_cyc, start_cyc;
   bit   hold_early;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory writes must appear in capture order at BASE (0) + dn_addr.
   function automatic logic [31:0] exp_addr(input logic [15:0] a);
      return (32'(a) + 32'd0) % (32'd1 << AW);
   endfunction

   task automatic tick();
      @(negedge clk_sys);
      if (chk_en) begin
         check("byte_count", 32'(byte_count), 32'(m_count));
         check("checksum", 32'(checksum), 32'(m_sum));
         check("overflow", 32'(overflow), 32'(m_ovf));
         if (mem_req) begin
            if (exp_q.size() == 0) begin
               check("unexpected_mem_req", 32'(mem_req), 32'd0);
            end else begin
               check("mem_addr", 32'(mem_addr), exp_addr(exp_q[0].addr));
               check("mem_dout", 32'(mem_dout), 32'(exp_q[0].data));
               if (mem_ack) begin
                  m_count++;
                  m_sum = m_sum + exp_q[0].data;
                  void'(exp_q.pop_front());
                  acks_seen++;
                  ack_cyc = cyc;
               end
            end
         end
      end
      if (cpu_start) begin
         starts++;
         start_cyc = cyc;
      end
      if (!cpu_hold && acks_seen < 3)
         hold_early = 1'b1;
      @(posedge clk_sys);
      #1;
      cyc++;
      if (mem_req && !ack_block)
         req_age++;
      else
         req_age = 0;
      mem_ack = force_ack || (mem_req && !ack_block && req_age > ack_lat);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++)
         tick();
   endtask

   task automatic start_load();
      chk_en = 1'b0;
      dn_go  = 1'b1;
      ticks(2);
      exp_q.delete();
      m_count = 0;
      m_sum   = 8'h00;
      m_ovf   = 1'b0;
      chk_en  = 1'b1;
   endtask

   task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit honor, input bit dropped);
      int guard;
      guard = 0;
      if (honor) begin
         while (dn_wait && guard < 200) begin
            tick();
            guard++;
         end
         if (guard >= 200)
            check("dn_wait_timeout", 32'(dn_wait), 32'd0);
      end
      dn_addr = a;
      dn_data = d;
      dn_wr   = 1'b1;
      tick();
      if (dropped)
         m_ovf = 1'b1;
      else
         exp_q.push_back(wr_t'({a, d}));
      dn_wr = 1'b0;
      tick();
   endtask

   task automatic wait_start(input int budget);
      int n;
      n = 0;
      while (starts == 0 && n < budget) begin
         tick();
         n++;
      end
      if (starts == 0)
         check("cpu_start_timeout", 32'(cpu_start), 32'd1);
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0; chk_en = 1'b0;
      ack_lat = 1; req_age = 0; ack_block = 1'b0; force_ack = 1'b0;
      acks_seen = 0; starts = 0; ack_cyc = 0; start_cyc = 0; hold_early = 1'b0;
      m_count = 0; m_sum = 8'h00; m_ovf = 1'b0;
      reset = 1'b1; dn_go = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
      execute_enable = 1'b0; execute_addr = '0; mem_ack = 1'b0;

      @(posedge clk_sys); #1;
      ticks(3);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_cpu_start", 32'(cpu_start), 32'd0);
      check("rst_byte_count", 32'(byte_count), 32'd0);
      check("rst_checksum", 32'(checksum), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_dn_wait", 32'(dn_wait), 32'd0);
      check("rst_start_addr", 32'(start_addr), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      tick();

      // Single byte: request one cycle after the edge, low again one cycle after the ack.
      ack_lat = 1;
      start_load();
      dn_addr = 16'h0010; dn_data = 8'hC3; dn_wr = 1'b1;
      tick();
      exp_q.push_back(wr_t'({16'h0010, 8'hC3}));
      check("single_req_latency", 32'(mem_req), 32'd1);
      check("single_mem_addr", 32'(mem_addr), 32'h000010);
      check("single_mem_dout", 32'(mem_dout), 32'hC3);
      dn_wr = 1'b0;
      tick();
      check("single_req_held", 32'(mem_req), 32'd1);
      tick();
      check("single_req_dropped", 32'(mem_req), 32'd0);
      check("single_byte_count", 32'(byte_count), 32'd1);
      check("single_checksum", 32'(checksum), 32'hC3);
      dn_go = 1'b0;
      ticks(4);
      check("single_hold_kept", 32'(cpu_hold), 32'd1);

      // 276-byte stream, loader honouring dn_wait.
      start_load();
      for (int i = 0; i < 276; i++)
         send_byte(16'(i), 8'(i), 1'b1, 1'b0);
      starts = 0;
      execute_addr   = 16'h0000;
      execute_enable = 1'b1;
      dn_go          = 1'b0;
      tick();
      execute_enable = 1'b0;
      wait_start(200);
      ticks(6);
      check("stream_starts", 32'(starts), 32'd1);
      check("stream_byte_count", 32'(byte_count), 32'd276);
      check("stream_checksum", 32'(checksum), 32'h3E);
      check("stream_overflow", 32'(overflow), 32'd0);
      check("stream_start_addr", 32'(start_addr), 32'h0000);
      check("stream_cpu_hold", 32'(cpu_hold), 32'd0);

      // Backpressure: one byte in flight plus four queued; the sixth is lost.
      start_load();
      ack_block = 1'b1;
      for (int k = 0; k < 6; k++) begin
         send_byte(16'h0200 + 16'(k), 8'hA0 + 8'(k), 1'b0, k == 5);
         if (k == 2)
            check("bp_dn_wait_low", 32'(dn_wait), 32'd0);
         if (k == 3)
            check("bp_dn_wait_high", 32'(dn_wait), 32'd1);
      end
      check("bp_overflow", 32'(overflow), 32'd1);
      check("bp_head_addr", 32'(mem_addr), 32'h000200);
      ticks(18);
      ack_block = 1'b0;
      begin
         int n;
         n = 0;
         while ((exp_q.size() != 0 || mem_req) && n < 200) begin
            tick();
            n++;
         end
         if (n >= 200)
            check("bp_drain_timeout", 32'(mem_req), 32'd0);
      end
      tick();
      check("bp_byte_count", 32'(byte_count), 32'd5);
      check("bp_checksum", 32'(checksum), 32'h2A);
      check("bp_dn_wait_clear", 32'(dn_wait), 32'd0);
      dn_go = 1'b0;
      ticks(4);
      check("bp_hold_kept", 32'(cpu_hold), 32'd1);

      // Execute with three bytes queued and a slow memory; exec shares the last edge.
      start_load();
      ack_lat = 4;
      hold_early = 1'b0;
      acks_seen = 0;
      starts = 0;
      send_byte(16'h0300, 8'h11, 1'b0, 1'b0);
      send_byte(16'h0301, 8'h22, 1'b0, 1'b0);
      dn_addr = 16'h0302; dn_data = 8'h33; dn_wr = 1'b1;
      execute_addr = 16'h0100; execute_enable = 1'b1;
      tick();
      exp_q.push_back(wr_t'({16'h0302, 8'h33}));
      dn_wr = 1'b0; execute_enable = 1'b0; dn_go = 1'b0;
      wait_start(200);
      check("exec_acks", 32'(acks_seen), 32'd3);
      check("exec_start_delay", 32'(start_cyc - ack_cyc), 32'd2);
      check("exec_hold_early", 32'(hold_early), 32'd0);
      check("exec_start_addr", 32'(start_addr), 32'h0100);
      check("exec_cpu_hold", 32'(cpu_hold), 32'd0);
      ticks(5);
      check("exec_starts", 32'(starts), 32'd1);
      check("exec_byte_count", 32'(byte_count), 32'd3);
      check("exec_checksum", 32'(checksum), 32'h66);

      // Base-address wrap on the second instance.
      ack_lat = 1;
      start_load();
      dn_addr = 16'h0020; dn_data = 8'h5A; dn_wr = 1'b1;
      tick();
      exp_q.push_back(wr_t'({16'h0020, 8'h5A}));
      check("wrap_req", 32'(b_mem_req), 32'd1);
      check("wrap_mem_addr", 32'(b_mem_addr), 32'h000010);
      check("wrap_mem_dout", 32'(b_mem_dout), 32'h5A);
      dn_wr = 1'b0;
      ticks(3);
      dn_go = 1'b0;
      ticks(4);

      // Reset in the middle of a load with a request outstanding.
      start_load();
      ack_block = 1'b1;
      send_byte(16'h0400, 8'h01, 1'b0, 1'b0);
      send_byte(16'h0401, 8'h02, 1'b0, 1'b0);
      send_byte(16'h0402, 8'h03, 1'b0, 1'b0);
      tick();
      check("rstmid_req_before", 32'(mem_req), 32'd1);
      chk_en = 1'b0;
      reset = 1'b1;
      dn_go = 1'b0;
      tick();
      check("rstmid_req_after", 32'(mem_req), 32'd0);
      check("rstmid_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rstmid_byte_count", 32'(byte_count), 32'd0);
      check("rstmid_dn_wait", 32'(dn_wait), 32'd0);
      reset = 1'b0;
      exp_q.delete();
      m_count = 0; m_sum = 8'h00; m_ovf = 1'b0;
      ack_block = 1'b0;
      chk_en = 1'b1;
      for (int j = 0; j < 3; j++) begin
         force_ack = 1'b1;
         tick();
         force_ack = 1'b0;
         ticks(2);
      end
      check("late_ack_byte_count", 32'(byte_count), 32'd0);
      check("late_ack_checksum", 32'(checksum), 32'd0);
      check("late_ack_mem_req", 32'(mem_req), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
